// File: rtl/gate_drive_pkg.sv
// Shared definitions for the gate-drive controller: IGBT FSM state encoding and
// default tick/timer sizing.
package gate_drive_pkg;

  typedef enum logic [1:0] {
    StOff  = 2'd0,
    StOn   = 2'd1,
    StHold = 2'd2
  } igbt_state_e;

  localparam int unsigned DefTickDiv = 50;
  localparam int unsigned DefCntW    = 16;

endpackage

// File: rtl/gate_drive_igbt_ch.sv
// One IGBT channel: OFF/ON/HOLD state machine enforcing min-on, min-off and max-on
// times, plus the re-arm and sticky timeout flags.
module gate_drive_igbt_ch
  import gate_drive_pkg::*;
#(
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             tick,
  input  logic             kill,
  input  logic             en,
  input  logic [CNT_W-1:0] min_on_t,
  input  logic [CNT_W-1:0] min_off_t,
  input  logic [CNT_W-1:0] max_on_t,
  output logic             gate,
  output logic             tmo
);

  localparam logic [CNT_W-1:0] TimerOne = CNT_W'(1);

  igbt_state_e      state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             armed_q, armed_d;
  logic             tmo_q, tmo_d;
  logic             timeout;

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    unique case (state_q)
      StOff: begin
        if (!kill && en && armed_q) state_d = StOn;
      end
      StOn: begin
        // Fault cuts the gate immediately; min-on is not honoured.
        if (kill) begin
          state_d = StOff;
        end else if (!en && (timer_q >= min_on_t)) begin
          state_d = StHold;
        end else if ((max_on_t != '0) && (timer_q >= max_on_t)) begin
          state_d = StHold;
          timeout = 1'b1;
        end
      end
      StHold: begin
        if (kill || (timer_q >= min_off_t)) state_d = StOff;
      end
      default: state_d = StOff;
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (tick && (timer_q != '1)) begin
      timer_d = timer_q + TimerOne;
    end

    // Armed stays clear for the whole fault so en must drop after the latch is cleared.
    armed_d = armed_q;
    if (kill || timeout) begin
      armed_d = 1'b0;
    end else if (!en) begin
      armed_d = 1'b1;
    end

    tmo_d = tmo_q;
    if (timeout) begin
      tmo_d = 1'b1;
    end else if (!en) begin
      tmo_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StOff;
      timer_q <= '0;
      armed_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      armed_q <= armed_d;
      tmo_q   <= tmo_d;
    end
  end

  assign gate = (state_q == StOn);
  assign tmo  = tmo_q;

endmodule

// File: rtl/gate_drive_ctrl.sv
// Parametrised IGBT/SCR gate-drive controller: tick prescaler, fault synchroniser and
// latch, SCR pulse trains, and one timed FSM per IGBT channel.
module gate_drive_ctrl
  import gate_drive_pkg::*;
#(
  parameter int unsigned N_IGBT   = 5,
  parameter int unsigned N_SCR    = 2,
  parameter int unsigned TICK_DIV = DefTickDiv,
  parameter int unsigned CNT_W    = DefCntW
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [N_IGBT-1:0] igbt_on_en,
  input  logic [N_SCR-1:0]  scr_on_en,
  input  logic [CNT_W-1:0]  min_on_t,
  input  logic [CNT_W-1:0]  min_off_t,
  input  logic [CNT_W-1:0]  max_on_t,
  input  logic [CNT_W-1:0]  scr_pulse_t,
  input  logic [CNT_W-1:0]  scr_period_t,
  input  logic              fault_n,
  input  logic              fault_clr,
  output logic [N_IGBT-1:0] igbt,
  output logic [N_IGBT-1:0] igbt_status,
  output logic [N_IGBT-1:0] igbt_tmo,
  output logic [N_SCR-1:0]  scr,
  output logic [N_SCR-1:0]  scr_status,
  output logic              fault_latched
);

  localparam int unsigned       PscW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PscW-1:0]   PscLast  = PscW'(TICK_DIV - 1);
  localparam logic [PscW-1:0]   PscOne   = PscW'(1);
  localparam logic [CNT_W:0]    PhaseOne = (CNT_W + 1)'(1);

  logic [PscW-1:0]  psc_q;
  logic             tick;
  logic [1:0]       fsync_q;
  logic             fault_s;
  logic             kill;
  logic             fault_latched_q, fault_latched_d;
  logic [N_SCR-1:0] scr_run, scr_d, scr_q, act_q;
  logic [CNT_W-1:0] phase_q [N_SCR];
  logic [CNT_W-1:0] phase_d [N_SCR];
  logic [CNT_W:0]   phase_nx;

  assign tick    = (psc_q == PscLast);
  assign fault_s = fsync_q[1];
  // Gates drop on the same edge the latch sets, not one cycle later.
  assign kill    = fault_latched_q | ~fault_s;

  always_comb begin
    fault_latched_d = fault_latched_q;
    if (!fault_s) begin
      fault_latched_d = 1'b1;
    end else if (fault_clr) begin
      fault_latched_d = 1'b0;
    end
  end

  for (genvar g = 0; g < N_IGBT; g++) begin : g_igbt
    gate_drive_igbt_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .tick      (tick),
      .kill      (kill),
      .en        (igbt_on_en[g]),
      .min_on_t  (min_on_t),
      .min_off_t (min_off_t),
      .max_on_t  (max_on_t),
      .gate      (igbt[g]),
      .tmo       (igbt_tmo[g])
    );
  end

  assign igbt_status = igbt;

  assign scr_run = scr_on_en & {N_SCR{~kill}};

  // Phase counts ticks within the period; the first cycle of a train restarts at phase 0.
  always_comb begin
    phase_nx = '0;
    for (int i = 0; i < N_SCR; i++) begin
      phase_nx   = {1'b0, phase_q[i]} + PhaseOne;
      phase_d[i] = '0;
      if (scr_run[i] && act_q[i]) begin
        if (!tick) begin
          phase_d[i] = phase_q[i];
        end else if (phase_nx < {1'b0, scr_period_t}) begin
          phase_d[i] = phase_nx[CNT_W-1:0];
        end
      end
      scr_d[i] = scr_run[i] && (scr_pulse_t != '0) &&
                 ((scr_period_t <= scr_pulse_t) || (phase_d[i] < scr_pulse_t));
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      psc_q           <= '0;
      fsync_q         <= 2'b11;
      fault_latched_q <= 1'b0;
      scr_q           <= '0;
      act_q           <= '0;
      for (int i = 0; i < N_SCR; i++) phase_q[i] <= '0;
    end else begin
      psc_q           <= tick ? '0 : psc_q + PscOne;
      fsync_q         <= {fsync_q[0], fault_n};
      fault_latched_q <= fault_latched_d;
      scr_q           <= scr_d;
      act_q           <= scr_run;
      for (int i = 0; i < N_SCR; i++) phase_q[i] <= phase_d[i];
    end
  end

  assign scr           = scr_q;
  assign scr_status    = act_q;
  assign fault_latched = fault_latched_q;

endmodule

// File: tb/tb_gate_drive_ctrl.sv
// Self-checking bench for gate_drive_ctrl: directed vectors, hand-written corner
// sequences and randomized traffic checked every cycle against a timestamp-based model.
module tb_gate_drive_ctrl;

  localparam int NI = 5;
  localparam int NS = 2;
  localparam int TD = 50;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [NI-1:0] igbt_on_en = '0;
  logic [NS-1:0] scr_on_en = '0;
  logic [15:0]   min_on_t = '0, min_off_t = '0, max_on_t = '0;
  logic [15:0]   scr_pulse_t = '0, scr_period_t = '0;
  logic          fault_n = 1'b1, fault_clr = 1'b0;
  logic [NI-1:0] igbt, igbt_status, igbt_tmo;
  logic [NS-1:0] scr, scr_status;
  logic          fault_latched;

  gate_drive_ctrl #(
    .N_IGBT(NI), .N_SCR(NS), .TICK_DIV(TD), .CNT_W(16)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .igbt_on_en    (igbt_on_en),
    .scr_on_en     (scr_on_en),
    .min_on_t      (min_on_t),
    .min_off_t     (min_off_t),
    .max_on_t      (max_on_t),
    .scr_pulse_t   (scr_pulse_t),
    .scr_period_t  (scr_period_t),
    .fault_n       (fault_n),
    .fault_clr     (fault_clr),
    .igbt          (igbt),
    .igbt_status   (igbt_status),
    .igbt_tmo      (igbt_tmo),
    .scr           (scr),
    .scr_status    (scr_status),
    .fault_latched (fault_latched)
  );

  initial forever #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // Reference model: edge index since reset, entry timestamps, tick counts by division.
  int            k_cyc;
  bit [NI-1:0]   m_gate, m_cool, m_armed, m_tmo;
  int            m_since [NI];
  bit [NS-1:0]   m_scr, m_act;
  int            m_start [NS];
  bit            m_fl, m_s0, m_s1;
  logic [19:0]   exp_v, act_v;

  function automatic int ticks_between(input int a, input int b);
    int t;
    t = b / TD - a / TD;
    if (t > 65535) t = 65535;
    return t;
  endfunction

  task automatic model_reset();
    k_cyc = 0;
    m_gate = '0; m_cool = '0; m_armed = '0; m_tmo = '0;
    m_scr = '0; m_act = '0;
    m_fl = 1'b0; m_s0 = 1'b1; m_s1 = 1'b1;
    for (int c = 0; c < NI; c++) m_since[c] = 0;
    for (int s = 0; s < NS; s++) m_start[s] = 0;
  endtask

  task automatic model_step();
    bit kill, nfl, en, to;
    int el, ph;
    k_cyc++;
    kill = m_fl || !m_s1;
    nfl = !m_s1 ? 1'b1 : (fault_clr ? 1'b0 : m_fl);
    m_s1 = m_s0;
    m_s0 = fault_n;
    for (int c = 0; c < NI; c++) begin
      en = igbt_on_en[c];
      to = 1'b0;
      el = ticks_between(m_since[c], k_cyc - 1);
      if (kill) begin
        m_gate[c] = 1'b0;
        m_cool[c] = 1'b0;
      end else if (m_gate[c]) begin
        if (!en && el >= int'(min_on_t)) begin
          m_gate[c] = 1'b0; m_cool[c] = 1'b1; m_since[c] = k_cyc;
        end else if (max_on_t != 0 && el >= int'(max_on_t)) begin
          m_gate[c] = 1'b0; m_cool[c] = 1'b1; m_since[c] = k_cyc; to = 1'b1;
        end
      end else if (m_cool[c]) begin
        if (el >= int'(min_off_t)) m_cool[c] = 1'b0;
      end else if (en && m_armed[c]) begin
        m_gate[c] = 1'b1;
        m_since[c] = k_cyc;
      end
      if (kill || to) m_armed[c] = 1'b0;
      else if (!en) m_armed[c] = 1'b1;
      if (to) m_tmo[c] = 1'b1;
      else if (!en) m_tmo[c] = 1'b0;
    end
    for (int s = 0; s < NS; s++) begin
      if (!(scr_on_en[s] && !kill)) begin
        m_scr[s] = 1'b0;
        m_act[s] = 1'b0;
      end else begin
        if (!m_act[s]) begin
          m_start[s] = k_cyc;
          m_act[s] = 1'b1;
        end
        if (scr_pulse_t == 0) begin
          m_scr[s] = 1'b0;
        end else if (scr_period_t <= scr_pulse_t) begin
          m_scr[s] = 1'b1;
        end else begin
          ph = (k_cyc / TD - m_start[s] / TD) % int'(scr_period_t);
          m_scr[s] = (ph < int'(scr_pulse_t));
        end
      end
    end
    m_fl = nfl;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) model_reset();
      else model_step();
    end
  end

  initial forever begin
    @(negedge sys_clk);
    if (chk_on) begin
      exp_v = {m_gate, m_gate, m_tmo, m_scr, m_act, m_fl};
      act_v = {igbt, igbt_status, igbt_tmo, scr, scr_status, fault_latched};
      n_chk++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL model_cycle%0d: got %h expected %h", k_cyc, act_v, exp_v);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic do_reset();
    igbt_on_en = '0; scr_on_en = '0; fault_n = 1'b1; fault_clr = 1'b0;
    #1 sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #3 sys_rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic set_t(input int on_t, input int off_t, input int max_t,
                       input int pul, input int per);
    min_on_t = 16'(on_t); min_off_t = 16'(off_t); max_on_t = 16'(max_t);
    scr_pulse_t = 16'(pul); scr_period_t = 16'(per);
  endtask

  typedef struct {
    int min_on, min_off, max_on, pulse, period, en_cyc, obs_cyc;
    int ig_lo, ig_hi, ig_rise, sc_lo, sc_hi, sc_rise;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int hi_i, hi_s, r_i, r_s, n;
    bit pi, ps;
    vecs[0] = '{10, 5, 0, 0, 10, 100, 2000, 450, 501, 1, 0, 0, 0};
    vecs[1] = '{0, 0, 20, 0, 0, 3000, 3000, 950, 1001, 1, 0, 0, 0};
    vecs[2] = '{0, 0, 0, 10, 100, 17500, 17600, 17500, 17500, 1, 1800, 2004, 4};
    vecs[3] = '{0, 0, 0, 10, 5, 1000, 1100, 1000, 1000, 1, 1000, 1000, 1};
    vecs[4] = '{0, 0, 0, 0, 10, 1000, 1100, 1000, 1000, 1, 0, 0, 0};
    vecs[5] = '{0, 0, 0, 3, 3, 500, 600, 500, 500, 1, 500, 500, 1};

    do_reset();
    chk_on = 1'b1;

    for (int v = 0; v < 6; v++) begin
      set_t(vecs[v].min_on, vecs[v].min_off, vecs[v].max_on, vecs[v].pulse, vecs[v].period);
      do_reset();
      hi_i = 0; hi_s = 0; r_i = 0; r_s = 0; pi = 1'b0; ps = 1'b0;
      for (int j = 0; j < vecs[v].obs_cyc; j++) begin
        igbt_on_en[0] = (j < vecs[v].en_cyc);
        scr_on_en[0]  = (j < vecs[v].en_cyc);
        cyc(1);
        if (igbt[0]) hi_i++;
        if (igbt[0] && !pi) r_i++;
        if (scr[0]) hi_s++;
        if (scr[0] && !ps) r_s++;
        pi = igbt[0];
        ps = scr[0];
      end
      check_rng($sformatf("v%0d_igbt_high", v), hi_i, vecs[v].ig_lo, vecs[v].ig_hi);
      check($sformatf("v%0d_igbt_rises", v), r_i, vecs[v].ig_rise);
      check_rng($sformatf("v%0d_scr_high", v), hi_s, vecs[v].sc_lo, vecs[v].sc_hi);
      check($sformatf("v%0d_scr_rises", v), r_s, vecs[v].sc_rise);
    end

    // Max-on timeout, sticky flag and re-arm.
    set_t(0, 0, 20, 0, 0);
    do_reset();
    igbt_on_en[0] = 1'b1;
    n = 0;
    while (n < 20 && !igbt[0]) begin cyc(1); n++; end
    n = 0;
    while (n < 2000 && igbt[0]) begin cyc(1); n++; end
    check_rng("tmo_high_time", n, 949, 1000);
    check("tmo_flag_set", int'(igbt_tmo[0]), 1);
    cyc(200);
    check("tmo_no_refire", int'(igbt[0]), 0);
    igbt_on_en[0] = 1'b0;
    cyc(2);
    check("tmo_flag_clear", int'(igbt_tmo[0]), 0);
    igbt_on_en[0] = 1'b1;
    cyc(2);
    check("tmo_refire", int'(igbt[0]), 1);

    // Fault mid-min-on, clear semantics, re-arm.
    set_t(100, 0, 0, 10, 100);
    do_reset();
    igbt_on_en = '1; scr_on_en = '1;
    cyc(20);
    check("fault_pre_on", int'({igbt, scr}), 7'h7f);
    fault_n = 1'b0;
    n = 0;
    while (n < 10 && (igbt != '0 || scr != '0)) begin cyc(1); n++; end
    check_rng("fault_gate_latency", n, 1, 3);
    check("fault_latched_set", int'(fault_latched), 1);
    fault_clr = 1'b1; cyc(1); fault_clr = 1'b0; cyc(1);
    check("fault_clr_ignored", int'(fault_latched), 1);
    fault_n = 1'b1;
    cyc(4);
    fault_clr = 1'b1; cyc(1); fault_clr = 1'b0;
    check("fault_clr_done", int'(fault_latched), 0);
    cyc(100);
    check("fault_no_refire", int'(igbt), 0);
    igbt_on_en = '0; cyc(1); igbt_on_en = '1; cyc(2);
    check("fault_refire", int'(igbt), 5'h1f);

    // Asynchronous reset while gates are on and SCR is mid-pulse.
    set_t(100, 0, 0, 10, 100);
    do_reset();
    igbt_on_en = '1; scr_on_en = '1;
    cyc(30);
    check("rst_pre_on", int'({igbt, scr}), 7'h7f);
    sys_rst_n = 1'b0;
    #1;
    check("rst_igbt_zero", int'(igbt), 0);
    check("rst_scr_zero", int'(scr), 0);
    check("rst_flags_zero", int'({igbt_tmo, scr_status, fault_latched}), 0);
    repeat (3) @(posedge sys_clk);
    #3 sys_rst_n = 1'b1;
    cyc(200);
    check("rst_no_refire", int'(igbt), 0);
    check("rst_scr_running", int'(scr_status), 2'b11);
    igbt_on_en = '0; cyc(1); igbt_on_en = '1; cyc(2);
    check("rst_refire", int'(igbt), 5'h1f);

    // Randomized traffic; the per-cycle model check does the comparing.
    do_reset();
    n = 0;
    for (int b = 0; b < 10; b++) begin
      scr_on_en = '0;
      cyc(1);
      set_t($urandom_range(0, 6), $urandom_range(0, 6),
            ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 8),
            $urandom_range(0, 4), $urandom_range(0, 8));
      for (int j = 0; j < 3000; j++) begin
        for (int c = 0; c < NI; c++)
          if ($urandom_range(0, 39) == 0) igbt_on_en[c] = ~igbt_on_en[c];
        for (int s = 0; s < NS; s++)
          if ($urandom_range(0, 59) == 0) scr_on_en[s] = ~scr_on_en[s];
        if ($urandom_range(0, 499) == 0) min_on_t = 16'($urandom_range(0, 6));
        if (n > 0) begin
          n--;
          if (n == 0) fault_n = 1'b1;
        end else if ($urandom_range(0, 2999) == 0) begin
          fault_n = 1'b0;
          n = $urandom_range(3, 30);
        end
        fault_clr = ($urandom_range(0, 99) == 0);
        cyc(1);
      end
    end

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
